// File: rtl/final_project_soc_from_sw_cmd_if.sv
// ---------------------------------------------------------------------------
// final_project_soc_from_sw_cmd_if
// Avalon-MM slave bus bundle between the Nios II data master and the
// command-output PIO.
//   address    [1:0]  register select
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data returned by the slave
// ---------------------------------------------------------------------------
interface final_project_soc_from_sw_cmd_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/final_project_soc_from_sw_cmd.sv
// ---------------------------------------------------------------------------
// final_project_soc_from_sw_cmd
// Software-written command register driven to the RSA datapath control FSM
// with a valid/ack handshake, plus set/clear bit access, a sticky overrun
// flag and a completed-transfer counter for software polling.
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   bus          Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port_o   current data register, driven to hardware
//   out_valid_o  command pending for hardware
//   out_ack_i    hardware accepts the pending command
// Register map: 0 DATA (rw), 1 STATUS {count[15:8], overrun[1], busy[0]},
//               2 OUTSET (wo), 3 OUTCLEAR (wo).
// ---------------------------------------------------------------------------
module final_project_soc_from_sw_cmd #(
  parameter int WIDTH       = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  final_project_soc_from_sw_cmd_if.slave   bus,
  output logic [WIDTH-1:0]                 out_port_o,
  output logic                             out_valid_o,
  input  logic                             out_ack_i
);

  localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RESET_VALUE);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_SET    = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  logic [WIDTH-1:0] data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       count_q,   count_d;
  logic [31:0]      rdata_q,   rdata_d;

  logic             wr_s;
  logic             ctrl_wr_s;
  logic             accept_s;
  logic             reject_s;
  logic             complete_s;
  logic [WIDTH-1:0] wdata_s;

  // Decode bus strobes into accept/reject/complete events.
  always_comb begin
    wr_s       = bus.chipselect & ~bus.write_n;
    // Everything except STATUS is blocked while a command is outstanding.
    ctrl_wr_s  = wr_s & (bus.address != ADDR_STATUS);
    accept_s   = ctrl_wr_s & ~valid_q;
    reject_s   = ctrl_wr_s & valid_q;
    complete_s = valid_q & out_ack_i;
    wdata_s    = bus.writedata[WIDTH-1:0];
  end

  // Next data register value and command-pending flag.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (complete_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    // accept_s implies valid_q=0, so it never races with completion.
    if (accept_s) begin
      case (bus.address)
        ADDR_DATA: begin
          data_d  = wdata_s;
          valid_d = 1'b1;
        end
        ADDR_SET:   data_d = data_q | wdata_s;
        ADDR_CLEAR: data_d = data_q & ~wdata_s;
        default:    data_d = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
  end

  // Sticky overrun flag and completed-transfer counter.
  always_comb begin
    overrun_d = overrun_q;
    count_d   = count_q;
    if (reject_s) begin
      overrun_d = 1'b1;
    end else if (wr_s && (bus.address == ADDR_STATUS) && bus.writedata[1]) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (complete_s) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Read mux, sampled every edge regardless of chipselect.
  always_comb begin
    rdata_d = 32'd0;
    case (bus.address)
      ADDR_DATA:   rdata_d = 32'(data_q);
      ADDR_STATUS: rdata_d = {16'd0, count_q, 6'd0, overrun_q, valid_q};
      default:     rdata_d = 32'd0;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q    <= RST_DATA;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= 8'd0;
      rdata_q   <= 32'd0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
    end
  end

  assign out_port_o   = data_q;
  assign out_valid_o  = valid_q;
  assign bus.readdata = rdata_q;

endmodule

// File: doc/final_project_soc_from_sw_cmd.md
Name: final_project_soc_from_sw_cmd

Overview:
- Avalon-MM slave output port: software writes a command word, and hardware sees it on `out_port` with a valid/ack handshake.
- Mirror of the read-only input PIO that returns hardware signals to software.
- Sits between the Nios II data master and the RSA datapath control FSM.
- Adds set/clear bit access, a sticky overrun flag and a completed-transfer counter so software can poll progress.

Parameters:
- WIDTH, 4, width of `out_port` and of the data register (1..16).
- RESET_VALUE, 0, value loaded into the data register on reset (low WIDTH bits used).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset_n  input  1  reset, synchronous active-low: sampled on the rising edge of `clk`.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  current data register, driven to hardware.
- out_valid  output  1  command pending for hardware.
- out_ack  input  1  hardware accepts the command.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - data=RESET_VALUE, out_valid=0, overrun=0, count=0, readdata=0.
  - Reset mid-handshake drops out_valid the next cycle, regardless of out_ack.
- Register map:
  - 0 DATA: read/write, bits[WIDTH-1:0].
  - 1 STATUS:
    - bit0 = busy (= out_valid).
    - bit1 = overrun (sticky).
    - bits[15:8] = count.
    - Writing with bit1=1 clears overrun; other bits are read-only.
  - 2 OUTSET: write-only, data |= writedata[WIDTH-1:0].
  - 3 OUTCLEAR: write-only, data &= ~writedata[WIDTH-1:0].
- Write acceptance:
  - Writes to addresses 0, 2 and 3 are accepted only if out_valid=0 at that edge.
  - If out_valid=1, the write is dropped (data unchanged) and overrun is set to 1.
  - A write to address 1 is always accepted.
- Command launch:
  - An accepted write to DATA loads data and sets out_valid=1 on the same edge.
  - out_port and out_valid therefore change together, 1 cycle after the write cycle.
  - OUTSET/OUTCLEAR update data/out_port with the same 1-cycle latency but do NOT assert out_valid (level control only).
- Handshake:
  - The transfer completes at any edge where out_valid=1 and out_ack=1.
  - On completion: out_valid<=0 and count<=count+1, wrapping 255->0.
  - out_ack while out_valid=0 is ignored (no count change).
  - out_port holds stable for the whole time out_valid=1.
- Simultaneous events:
  - Completion edge plus a DATA write on the same edge: the write is rejected (out_valid was 1), overrun<=1, and out_valid ends at 0.
  - A STATUS clear-overrun write on the same edge as an overrun-setting event cannot occur, since both are writes on one bus.
- Read path:
  - readdata updates every clk edge from address, independent of chipselect.
  - Read latency is 1 cycle.
  - Unused bits read 0; addresses 2 and 3 read 0.
  - DATA is zero-extended to 32 bits.
- writedata bits above WIDTH are ignored.

Test Plan:
1. Reset with RESET_VALUE=0, then write DATA=0x5 -> next cycle out_port=0x5, out_valid=1. Hold out_ack=0 for 10 cycles -> out_valid stays 1. Pulse out_ack=1 for one cycle -> out_valid=0 next cycle, STATUS reads 0x00000100.
2. While busy, write DATA=0xA -> out_port stays 0x5, STATUS bit1=1. Write STATUS=0x2 -> overrun cleared, STATUS bit1 reads 0.
3. Idle with data=0x5: OUTSET 0x8 -> out_port=0xD; OUTCLEAR 0x1 -> out_port=0xC; out_valid stays 0 and count is unchanged.
4. Write DATA on the exact edge where out_ack completes a pending transfer -> write rejected, overrun=1, out_valid=0, count incremented by 1.
5. Run 256 complete handshakes -> count wraps to 0x00, then one more -> STATUS bits[15:8]=0x01. Out_ack pulses with out_valid=0 -> count unchanged.
6. Assert reset_n=0 for one edge mid-handshake (out_valid=1, data=0x7) -> next cycle out_valid=0, out_port=0, readdata=0, count=0.
